fence_t_seq: RTL

Parametrised temporal-fence sequencer for the core's controller. On a fence.t request it flushes a configurable set of cache channels, each with its own req/ack handshake. It then waits for all handshaked interfaces to go idle and for the time-interrupt pad to expire, and finally holds the microarchitecture in reset for a configurable number of cycles. It replaces the fixed single-cache fence.t FSM inside the flush controller and adds a per-request channel mask and mode bits.

---
 rtl/ariane_pkg.sv | 18 +
 rtl/fence_t_seq_counter.sv | 27 ++
 rtl/fence_t_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared controller types: fence.t sequencer state encoding and per-request mode bits.
package ariane_pkg;

    localparam int unsigned VLEN = 64;

    typedef enum logic [1:0] {
        FENCE_IDLE,
        FENCE_FLUSH,
        FENCE_DRAIN,
        FENCE_RST_UARCH
    } fence_t_state_e;

    typedef struct packed {
        logic skip_flush;
        logic skip_pad;
    } fence_t_mode_t;

endpackage

// File: rtl/fence_t_seq_counter.sv
// Generic loadable up/down counter; load has priority over counting.
module fence_t_seq_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             en,
    input  logic             load,
    input  logic             down,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= down ? q - WIDTH'(1) : q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fence_t_seq.sv
// Temporal-fence sequencer: flush selected cache channels, drain interfaces and the
// time-interrupt pad, then hold the microarchitecture in reset for RstCycles cycles.
module fence_t_seq
    import ariane_pkg::*;
#(
    parameter int unsigned NrChan    = 2,
    parameter int unsigned NrBusy    = 1,
    parameter int unsigned RstCycles = 16,
    parameter int unsigned PadWidth  = 32,
    parameter int unsigned AddrWidth = ariane_pkg::VLEN
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] boot_addr_i,
    input  logic                 fence_req_i,
    input  fence_t_mode_t        fence_mode_i,
    input  logic [NrChan-1:0]    chan_en_i,
    input  logic [AddrWidth-1:0] pc_commit_i,
    output logic [NrChan-1:0]    flush_req_o,
    input  logic [NrChan-1:0]    flush_ack_i,
    input  logic [NrBusy-1:0]    busy_i,
    input  logic                 time_irq_i,
    input  logic [PadWidth-1:0]  pad_i,
    output logic                 halt_o,
    output logic                 rst_uarch_no,
    output logic [AddrWidth-1:0] rst_addr_o,
    output logic                 done_o
);

    localparam int unsigned RstCntW = $clog2(RstCycles + 1);

    fence_t_state_e       state_q;
    logic [NrChan-1:0]    pend_q;
    logic [NrChan-1:0]    pend_left;
    logic                 skip_pad_q;
    logic [AddrWidth-1:0] rst_addr_q;
    logic [RstCntW-1:0]   rst_cnt_q;
    logic                 rst_uarch_q;
    logic                 done_q;
    logic                 time_irq_q;
    logic [PadWidth-1:0]  pad_cnt;
    logic                 pad_load;
    logic                 pad_expired;

    assign pend_left   = pend_q & ~flush_ack_i;
    assign pad_load    = time_irq_i & ~time_irq_q;
    assign pad_expired = (pad_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            time_irq_q <= 1'b0;
        end else begin
            time_irq_q <= time_irq_i;
        end
    end

    // Pad timer counts down to zero and holds; a fresh irq edge reloads it mid-count.
    fence_t_seq_counter #(
        .WIDTH(PadWidth)
    ) i_pad_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clear (1'b0),
        .en    (!pad_expired),
        .load  (pad_load),
        .down  (1'b1),
        .d     (pad_i),
        .q     (pad_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FENCE_IDLE;
            pend_q      <= '0;
            skip_pad_q  <= 1'b0;
            rst_addr_q  <= boot_addr_i;
            rst_cnt_q   <= '0;
            rst_uarch_q <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                FENCE_IDLE: begin
                    if (fence_req_i) begin
                        skip_pad_q <= fence_mode_i.skip_pad;
                        rst_addr_q <= pc_commit_i + AddrWidth'(4);
                        if (fence_mode_i.skip_flush || chan_en_i == '0) begin
                            state_q <= FENCE_DRAIN;
                        end else begin
                            pend_q  <= chan_en_i;
                            state_q <= FENCE_FLUSH;
                        end
                    end
                end
                FENCE_FLUSH: begin
                    // Leave as soon as the final ack lands, without waiting a cycle.
                    pend_q <= pend_left;
                    if (pend_left == '0) begin
                        state_q <= FENCE_DRAIN;
                    end
                end
                FENCE_DRAIN: begin
                    if (busy_i == '0 && (skip_pad_q || pad_expired)) begin
                        state_q     <= FENCE_RST_UARCH;
                        rst_uarch_q <= 1'b0;
                    end
                end
                FENCE_RST_UARCH: begin
                    if (rst_cnt_q == RstCntW'(RstCycles - 1)) begin
                        rst_cnt_q   <= '0;
                        rst_uarch_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= FENCE_IDLE;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RstCntW'(1);
                    end
                end
                default: begin
                    state_q     <= FENCE_IDLE;
                    pend_q      <= '0;
                    rst_cnt_q   <= '0;
                    rst_uarch_q <= 1'b1;
                end
            endcase
        end
    end

    assign flush_req_o  = pend_q;
    assign halt_o       = (state_q != FENCE_IDLE);
    assign rst_uarch_no = rst_uarch_q;
    assign rst_addr_o   = rst_addr_q;
    assign done_o       = done_q;

endmodule
